ahb_sram_arbiter: RTL and testbench

- Shares one single-port 32-bit SRAM bank between two AHB-lite masters: the SPI loader (master 0) and the RISC-V core data port (master 1).
- Each master's address phase is captured into a per-master pending slot. One transfer is granted at a time. The master's data phase is stalled via hready until its transfer is served.
- Holds the core off until the boot load completes.
- Sits between the AHB masters and the SRAM macro. Replaces ad-hoc mode muxing in the routing layer.

---
 rtl/ahb_sram_pkg.sv | 54 +++++
 rtl/ahb_pend_slot.sv | 41 ++++
 rtl/ahb_sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ahb_sram_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared constants and helpers for the AHB-lite to single-port SRAM arbiter.
package ahb_sram_pkg;

  localparam int DEFAULT_ADDR_W = 14;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_RD_DATA = 2'd1;
  localparam arb_state_t ST_ERR1    = 2'd2;
  localparam arb_state_t ST_ERR2    = 2'd3;

  function automatic logic trans_active(input logic [1:0] htrans);
    logic active;
    active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    return active;
  endfunction

  // Write data is not lane-shifted, so the enables simply select which lanes land.
  function automatic logic [3:0] byte_enable(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic access_error(input logic [31:0] haddr, input logic [2:0] hsize,
                                        input int addr_w);
    logic out_of_range;
    out_of_range = (haddr >> (addr_w + 2)) != 32'd0;
    return out_of_range || (hsize > HSIZE_WORD) ||
           ((hsize == HSIZE_HALF) && haddr[0]) ||
           ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_pend_slot.sv
// Per-master AHB-lite address-phase capture register and hready generation.
module ahb_pend_slot
  import ahb_sram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        complete,
  output logic        hready,
  output logic        pend,
  output logic [31:0] addr,
  output logic        write,
  output logic [2:0]  size
);

  logic capture;

  // Completing the held transfer frees the slot in the same cycle, allowing a pipelined reload.
  assign hready  = !pend || complete;
  assign capture = hready && trans_active(htrans);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend  <= 1'b0;
      addr  <= '0;
      write <= 1'b0;
      size  <= '0;
    end else if (capture) begin
      pend  <= 1'b1;
      addr  <= haddr;
      write <= hwrite;
      size  <= hsize;
    end else if (complete) begin
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Shares one single-port SRAM between the SPI loader (master 0) and the core data port (master 1).
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both masters contend.
module ahb_sram_arbiter
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_done,
  input  logic [31:0]       spi_haddr,
  input  logic [1:0]        spi_htrans,
  input  logic              spi_hwrite,
  input  logic [2:0]        spi_hsize,
  input  logic [31:0]       spi_hwdata,
  output logic              spi_hready,
  output logic              spi_hresp,
  output logic [31:0]       spi_hrdata,
  input  logic [31:0]       core_haddr,
  input  logic [1:0]        core_htrans,
  input  logic              core_hwrite,
  input  logic [2:0]        core_hsize,
  input  logic [31:0]       core_hwdata,
  output logic              core_hready,
  output logic              core_hresp,
  output logic [31:0]       core_hrdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic [3:0]        sram_wben,
  output logic              sram_rwn,
  input  logic [31:0]       sram_rdata
);

  logic        pend0, pend1;
  logic        write0, write1;
  logic [31:0] addr0, addr1;
  logic [2:0]  size0, size1;
  logic        complete0, complete1;

  arb_state_t  state;
  logic        owner;
  logic        boot_flag;

  logic        gnt_valid, gnt_sel;
  logic [31:0] g_addr, g_wdata;
  logic [2:0]  g_size;
  logic        g_write, g_err;
  logic        idle_grant, do_write, do_read;
  logic        owner_done, err_state;

  ahb_pend_slot u_slot_spi (
    .clk      (clk),
    .reset    (reset),
    .haddr    (spi_haddr),
    .htrans   (spi_htrans),
    .hwrite   (spi_hwrite),
    .hsize    (spi_hsize),
    .complete (complete0),
    .hready   (spi_hready),
    .pend     (pend0),
    .addr     (addr0),
    .write    (write0),
    .size     (size0)
  );

  ahb_pend_slot u_slot_core (
    .clk      (clk),
    .reset    (reset),
    .haddr    (core_haddr),
    .htrans   (core_htrans),
    .hwrite   (core_hwrite),
    .hsize    (core_hsize),
    .complete (complete1),
    .hready   (core_hready),
    .pend     (pend1),
    .addr     (addr1),
    .write    (write1),
    .size     (size1)
  );

  // The core is locked out until the loader signals completion at least once.
  assign gnt_valid = pend0 || (pend1 && boot_flag);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
    end else if (idle_grant) begin
      last_gnt <= gnt_sel;
    end
  end

  always_comb begin
    gnt_sel = !pend0;
    if (pend0 && pend1 && boot_flag) begin
      gnt_sel = !last_gnt;
    end
  end
`else
  assign gnt_sel = !pend0;
`endif

  assign g_addr  = gnt_sel ? addr1 : addr0;
  assign g_size  = gnt_sel ? size1 : size0;
  assign g_write = gnt_sel ? write1 : write0;
  assign g_wdata = gnt_sel ? core_hwdata : spi_hwdata;
  assign g_err   = access_error(g_addr, g_size, ADDR_W);

  assign idle_grant = (state == ST_IDLE) && gnt_valid;
  assign do_write   = idle_grant && !g_err && g_write;
  assign do_read    = idle_grant && !g_err && !g_write;

  always_comb begin
    sram_rwn   = 1'b1;
    sram_wben  = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (do_write || do_read) begin
      sram_addr = g_addr[ADDR_W+1:2];
    end
    if (do_write) begin
      sram_rwn   = 1'b0;
      sram_wben  = byte_enable(g_size, g_addr[1:0]);
      sram_wdata = g_wdata;
    end
  end

  assign owner_done = (state == ST_RD_DATA) || (state == ST_ERR2);
  assign err_state  = (state == ST_ERR1) || (state == ST_ERR2);

  assign complete0 = (do_write && !gnt_sel) || (owner_done && !owner);
  assign complete1 = (do_write &&  gnt_sel) || (owner_done &&  owner);

  assign spi_hresp   = err_state && !owner;
  assign core_hresp  = err_state &&  owner;
  assign spi_hrdata  = ((state == ST_RD_DATA) && !owner) ? sram_rdata : '0;
  assign core_hrdata = ((state == ST_RD_DATA) &&  owner) ? sram_rdata : '0;

  // Writes finish in the grant cycle; reads and errors hold the owner for the follow-up states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      boot_flag <= 1'b0;
    end else begin
      if (boot_done) begin
        boot_flag <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (idle_grant) begin
            owner <= gnt_sel;
            if (g_err) begin
              state <= ST_ERR1;
            end else if (!g_write) begin
              state <= ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA: state <= ST_IDLE;
        ST_ERR1:    state <= ST_ERR2;
        ST_ERR2:    state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Self-checking bench for ahb_sram_arbiter: directed steps plus randomized transfers
// checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_ahb_sram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              boot_done;
  logic [31:0]       spi_haddr, spi_hwdata, spi_hrdata;
  logic [1:0]        spi_htrans;
  logic              spi_hwrite, spi_hready, spi_hresp;
  logic [2:0]        spi_hsize;
  logic [31:0]       core_haddr, core_hwdata, core_hrdata;
  logic [1:0]        core_htrans;
  logic              core_hwrite, core_hready, core_hresp;
  logic [2:0]        core_hsize;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata, sram_rdata;
  logic [3:0]        sram_wben;
  logic              sram_rwn;

  logic [31:0] mem    [DEPTH];
  logic [31:0] shadow [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;
  int          rr_last;

  typedef struct {
    int          cycles;
    logic        resp, prev_resp, saw_write, last_rwn, prev_rwn;
    logic [31:0] last_addr, prev_addr, last_wdata, rdata;
    logic [3:0]  last_wben;
  } obs_t;

  always #5 clk = ~clk;

  ahb_sram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .boot_done   (boot_done),
    .spi_haddr   (spi_haddr),
    .spi_htrans  (spi_htrans),
    .spi_hwrite  (spi_hwrite),
    .spi_hsize   (spi_hsize),
    .spi_hwdata  (spi_hwdata),
    .spi_hready  (spi_hready),
    .spi_hresp   (spi_hresp),
    .spi_hrdata  (spi_hrdata),
    .core_haddr  (core_haddr),
    .core_htrans (core_htrans),
    .core_hwrite (core_hwrite),
    .core_hsize  (core_hsize),
    .core_hwdata (core_hwdata),
    .core_hready (core_hready),
    .core_hresp  (core_hresp),
    .core_hrdata (core_hrdata),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wben   (sram_wben),
    .sram_rwn    (sram_rwn),
    .sram_rdata  (sram_rdata)
  );

  // SRAM macro model: byte-masked writes, read data one cycle after the address.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sram_rdata <= '0;
    end else begin
      if (!sram_rwn) begin
        for (int b = 0; b < 4; b++)
          if (sram_wben[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setAddrPhase(input int m, input logic wr, input logic [31:0] addr, input logic [2:0] size);
    if (m == 0) begin
      spi_htrans = 2'b10; spi_haddr = addr; spi_hwrite = wr; spi_hsize = size;
    end else begin
      core_htrans = 2'b10; core_haddr = addr; core_hwrite = wr; core_hsize = size;
    end
  endtask

  task automatic setIdle(input int m, input logic [31:0] wdata);
    if (m == 0) begin
      spi_htrans = 2'b00; spi_hwdata = wdata;
    end else begin
      core_htrans = 2'b00; core_hwdata = wdata;
    end
  endtask

  task automatic applyStimulus(input int m, input logic wr, input logic [31:0] addr, input logic [2:0] size);
    setAddrPhase(m, wr, addr, size);
    @(posedge clk); #1;
  endtask

  task automatic waitDone(input int m, output obs_t o);
    bit done;
    done = 0;
    o.cycles = 0; o.resp = 0; o.prev_resp = 0; o.saw_write = 0; o.last_rwn = 1; o.prev_rwn = 1;
    o.last_addr = 0; o.prev_addr = 0; o.last_wdata = 0; o.rdata = 0; o.last_wben = 0;
    while (!done && o.cycles < 16) begin
      @(negedge clk);
      o.cycles++;
      o.prev_resp = o.resp;
      o.prev_addr = o.last_addr;
      o.prev_rwn  = o.last_rwn;
      o.resp       = (m == 0) ? spi_hresp : core_hresp;
      o.last_addr  = 32'(sram_addr);
      o.last_rwn   = sram_rwn;
      o.last_wben  = sram_wben;
      o.last_wdata = sram_wdata;
      if (!sram_rwn) o.saw_write = 1;
      if ((m == 0) ? spi_hready : core_hready) begin
        done = 1;
        o.rdata = (m == 0) ? spi_hrdata : core_hrdata;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic bit isErr(input logic [31:0] addr, input logic [2:0] size);
    if (addr >= 32'(4 * DEPTH)) return 1;
    if (size > 3'd2) return 1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [3:0] expWben(input logic [31:0] addr, input logic [2:0] size);
    if (size == 3'd0) return 4'(1 << (addr % 4));
    if (size == 3'd1) return 4'(3 << (addr % 4));
    return 4'hF;
  endfunction

  // Expected outcome from the transfer rules: 1 cycle write, 2 cycle read, 3 cycle error.
  task automatic checkTransfer(input string tag, input int m, input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata, input int extra,
                               input obs_t o);
    int         word;
    logic [3:0] be;
    word = int'((addr >> 2) % DEPTH);
    if (isErr(addr, size)) begin
      checkOutput($sformatf("%s_cycles", tag), o.cycles, 3 + extra);
      checkOutput($sformatf("%s_err1_hresp", tag), o.prev_resp, 1);
      checkOutput($sformatf("%s_err2_hresp", tag), o.resp, 1);
      checkOutput($sformatf("%s_no_write", tag), o.saw_write, 0);
    end else if (wr) begin
      be = expWben(addr, size);
      checkOutput($sformatf("%s_cycles", tag), o.cycles, 1 + extra);
      checkOutput($sformatf("%s_hresp", tag), o.resp, 0);
      checkOutput($sformatf("%s_rwn", tag), o.last_rwn, 0);
      checkOutput($sformatf("%s_addr", tag), o.last_addr, word);
      checkOutput($sformatf("%s_wben", tag), o.last_wben, be);
      checkOutput($sformatf("%s_wdata", tag), o.last_wdata, wdata);
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[word][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      checkOutput($sformatf("%s_cycles", tag), o.cycles, 2 + extra);
      checkOutput($sformatf("%s_hresp", tag), o.resp, 0);
      checkOutput($sformatf("%s_rd_rwn", tag), o.prev_rwn, 1);
      checkOutput($sformatf("%s_rd_addr", tag), o.prev_addr, word);
      checkOutput($sformatf("%s_hrdata", tag), o.rdata, shadow[word]);
    end
    rr_last = m;
  endtask

  task automatic runTransfer(input string tag, input int m, input logic wr, input logic [31:0] addr,
                             input logic [2:0] size, input logic [31:0] wdata);
    obs_t o;
    applyStimulus(m, wr, addr, size);
    setIdle(m, wdata);
    waitDone(m, o);
    checkTransfer(tag, m, wr, addr, size, wdata, 0, o);
  endtask

  // Simultaneous reads: the winner finishes after 2 cycles, the other after 4.
  task automatic runConflict(input string tag, input logic [31:0] a0, input logic [31:0] a1);
    int          first, t0, t1;
    logic [31:0] d0, d1;
`ifdef ARB_ROUND_ROBIN_EN
    first = 1 - rr_last;
`else
    first = 0;
`endif
    t0 = 0; t1 = 0; d0 = 0; d1 = 0;
    setAddrPhase(0, 1'b0, a0, 3'd2);
    setAddrPhase(1, 1'b0, a1, 3'd2);
    @(posedge clk); #1;
    setIdle(0, 32'h0);
    setIdle(1, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (t0 == 0 && spi_hready)  begin t0 = c; d0 = spi_hrdata;  end
      if (t1 == 0 && core_hready) begin t1 = c; d1 = core_hrdata; end
      @(posedge clk); #1;
      if (t0 != 0 && t1 != 0) break;
    end
    checkOutput($sformatf("%s_spi_cycles", tag),  t0, (first == 0) ? 2 : 4);
    checkOutput($sformatf("%s_core_cycles", tag), t1, (first == 1) ? 2 : 4);
    checkOutput($sformatf("%s_spi_hrdata", tag),  d0, shadow[int'(a0 >> 2)]);
    checkOutput($sformatf("%s_core_hrdata", tag), d1, shadow[int'(a1 >> 2)]);
    rr_last = 1 - first;
  endtask

  initial begin
    obs_t o;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    rr_last = 1;

    // Reset with both masters actively requesting.
    reset = 1'b1;
    boot_done = 1'b0;
    setAddrPhase(0, 1'b1, 32'h4, 3'd2);
    setAddrPhase(1, 1'b1, 32'h8, 3'd2);
    spi_hwdata = 32'hFFFF_FFFF;
    core_hwdata = 32'hFFFF_FFFF;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_spi_hready", spi_hready, 1);
    checkOutput("rst_core_hready", core_hready, 1);
    checkOutput("rst_spi_hresp", spi_hresp, 0);
    checkOutput("rst_core_hresp", core_hresp, 0);
    checkOutput("rst_spi_hrdata", spi_hrdata, 0);
    checkOutput("rst_core_hrdata", core_hrdata, 0);
    checkOutput("rst_sram_rwn", sram_rwn, 1);
    checkOutput("rst_sram_wben", sram_wben, 0);
    checkOutput("rst_sram_addr", 32'(sram_addr), 0);
    checkOutput("rst_sram_wdata", sram_wdata, 0);
    setIdle(0, 32'h0);
    setIdle(1, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_rst_rwn", sram_rwn, 1);
      checkOutput("post_rst_wben", sram_wben, 0);
      @(posedge clk); #1;
    end

    // Core is held off while boot is incomplete; the loader proceeds.
    runTransfer("boot_spi_wr10", 0, 1'b1, 32'h10, 3'd2, 32'hCAFE_F00D);
    applyStimulus(1, 1'b0, 32'h10, 3'd2);
    setIdle(1, 32'h0);
    runTransfer("boot_spi_wr4", 0, 1'b1, 32'h4, 3'd2, 32'hDEAD_BEEF);
    repeat (3) begin
      @(negedge clk);
      checkOutput("boot_core_held", core_hready, 0);
      checkOutput("boot_no_access_rwn", sram_rwn, 1);
      @(posedge clk); #1;
    end
    boot_done = 1'b1;
    waitDone(1, o);
    checkTransfer("boot_core_rd", 1, 1'b0, 32'h10, 3'd2, 32'h0, 1, o);
    boot_done = 1'b0;

    // Basic read, then sub-word writes and their read-back merges.
    runTransfer("spi_wr8", 0, 1'b1, 32'h8, 3'd2, 32'h1234_5678);
    runTransfer("core_rd8", 1, 1'b0, 32'h8, 3'd2, 32'h0);
    runTransfer("core_wr_byte6", 1, 1'b1, 32'h6, 3'd0, 32'hA1B2_C3D4);
    runTransfer("core_wr_half10", 1, 1'b1, 32'hA, 3'd1, 32'h5566_7788);
    runTransfer("core_rd4", 1, 1'b0, 32'h4, 3'd2, 32'h0);
    runTransfer("spi_rd8", 0, 1'b0, 32'h8, 3'd2, 32'h0);

    // Error responses.
    runTransfer("err_range", 1, 1'b0, 32'h0001_0000, 3'd2, 32'h0);
    runTransfer("err_half_misalign", 1, 1'b1, 32'h3, 3'd1, 32'hFFFF_FFFF);
    runTransfer("err_size", 0, 1'b1, 32'h0, 3'd3, 32'hFFFF_FFFF);
    runTransfer("after_err_rd0", 0, 1'b0, 32'h0, 3'd2, 32'h0);

    // Pipelined back-to-back writes from the loader.
    applyStimulus(0, 1'b1, 32'h20, 3'd2);
    spi_hwdata = 32'h1111_2222;
    spi_haddr = 32'h24;
    @(negedge clk);
    checkOutput("b2b_a_hready", spi_hready, 1);
    checkOutput("b2b_a_addr", 32'(sram_addr), 8);
    checkOutput("b2b_a_wdata", sram_wdata, 32'h1111_2222);
    @(posedge clk); #1;
    setIdle(0, 32'h3333_4444);
    @(negedge clk);
    checkOutput("b2b_b_hready", spi_hready, 1);
    checkOutput("b2b_b_addr", 32'(sram_addr), 9);
    checkOutput("b2b_b_wdata", sram_wdata, 32'h3333_4444);
    @(posedge clk); #1;
    shadow[8] = 32'h1111_2222;
    shadow[9] = 32'h3333_4444;
    rr_last = 0;
    runTransfer("b2b_rd24", 1, 1'b0, 32'h24, 3'd2, 32'h0);

    runConflict("conflict1", 32'h4, 32'h8);

    for (int i = 0; i < 48; i++) begin
      int          rm;
      logic        rwr;
      logic [2:0]  rsize;
      logic [31:0] raddr, rdat;
      rm    = int'($urandom_range(0, 1));
      rwr   = 1'($urandom_range(0, 1));
      rsize = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      raddr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0) raddr = raddr & ~((32'd1 << rsize) - 32'd1);
      if ($urandom_range(0, 9) == 0) raddr = raddr | (32'h0001_0000 << $urandom_range(0, 15));
      rdat  = $urandom;
      runTransfer($sformatf("rnd%0d", i), rm, rwr, raddr, rsize, rdat);
    end

    runConflict("conflict2", 32'h10, 32'h24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
